uart_tx_param: RTL

Parametrised UART transmitter, the successor to the fixed-width TX block: serialises a DATA_WIDTH-bit word as start, data LSB-first, optional parity and one or two stop bits. It has an internal baud divider and a one-entry holding register, so frames can be sent back-to-back. It sits between a parallel producer (Data_Valid/P_DATA with a ready handshake) and the serial line TX_OUT.

---
 rtl/uart_tx_param.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_param
//  Purpose  : Parametrised UART transmitter. Sends a DATA_WIDTH-bit word as
//             start bit, data bits LSB first, an optional parity bit, then one
//             or two stop bits. Each bit lasts CLKS_PER_BIT clocks. A one-entry
//             holding register lets the next word be queued during a frame,
//             so that frames can follow each other with no idle gap.
//  Params   : DATA_WIDTH   (5..9)  data bits per frame
//             CLKS_PER_BIT (>= 1)  clock cycles per serial bit
//  Ports    : CLK, RST (synchronous, active high)
//             Data_Valid, P_DATA                 producer side, with ready
//             parity_enable, parity_type (0 even / 1 odd), stop_two
//             ready       holding register empty
//             busy        frame in progress
//             frame_done  one-cycle pulse on the last cycle of the last stop bit
//             TX_OUT      serial line, idles high
//  Macro    : UART_TX_PARITY_EN builds the parity generator and PARITY state;
//             without it parity_enable/parity_type are ignored.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_param #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Data_Valid,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    input  logic                  stop_two,
    output logic                  ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  TX_OUT
);

    localparam int                 c_CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_BAUD_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]         c_DATA_LAST = 4'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        , S_PARITY = 3'd4
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [c_CNT_W-1:0]      baud_q, baud_d;
    logic [3:0]              bit_q, bit_d;        // data bit index, or stop bit index
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    frm_stop2_q, frm_stop2_d;
    logic                    hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0]   hold_data_q, hold_data_d;
    logic                    hold_stop2_q, hold_stop2_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    ready_q, ready_d;
`ifdef UART_TX_PARITY_EN
    logic                    hold_par_en_q, hold_par_en_d;
    logic                    hold_par_bit_q, hold_par_bit_d;
    logic                    frm_par_en_q, frm_par_en_d;
    logic                    frm_par_bit_q, frm_par_bit_d;
`else
    logic                    w_unused_parity;
    assign w_unused_parity = parity_enable ^ parity_type;
`endif

    logic w_bit_end;
    logic w_load;

    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        frm_stop2_d  = frm_stop2_q;
        hold_full_d  = hold_full_q;
        hold_data_d  = hold_data_q;
        hold_stop2_d = hold_stop2_q;
`ifdef UART_TX_PARITY_EN
        hold_par_en_d  = hold_par_en_q;
        hold_par_bit_d = hold_par_bit_q;
        frm_par_en_d   = frm_par_en_q;
        frm_par_bit_d  = frm_par_bit_q;
`endif
        w_bit_end = (baud_q == c_BAUD_LAST);
        w_load    = 1'b0;

        case (state_q)
            S_IDLE: begin
                w_load = hold_full_q;
            end
            S_START: begin
                if (w_bit_end) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = 4'd0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    shift_d = shift_q >> 1;
                    baud_d  = '0;
                    if (bit_q == c_DATA_LAST) begin
                        bit_d = 4'd0;
`ifdef UART_TX_PARITY_EN
                        state_d = frm_par_en_q ? S_PARITY : S_STOP;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    state_d = S_STOP;
                    baud_d  = '0;
                    bit_d   = 4'd0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    baud_d = '0;
                    if (frm_stop2_q && (bit_q == 4'd0)) begin
                        bit_d = 4'd1;
                    end else if (hold_full_q) begin
                        // Next word already waiting: start bit follows with no gap.
                        w_load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        bit_d   = 4'd0;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = 4'd0;
            end
        endcase

        // Move the held word (and its frame options) into the shifter.
        if (w_load) begin
            state_d     = S_START;
            baud_d      = '0;
            bit_d       = 4'd0;
            shift_d     = hold_data_q;
            frm_stop2_d = hold_stop2_q;
            hold_full_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            frm_par_en_d  = hold_par_en_q;
            frm_par_bit_d = hold_par_bit_q;
`endif
        end

        // Acceptance needs an empty holding register, so it never collides
        // with a load in the same cycle.
        if (Data_Valid && ready_q) begin
            hold_full_d  = 1'b1;
            hold_data_d  = P_DATA;
            hold_stop2_d = stop_two;
`ifdef UART_TX_PARITY_EN
            hold_par_en_d  = parity_enable;
            hold_par_bit_d = parity_type ? ~^P_DATA : ^P_DATA;
`endif
        end

        // Outputs are derived from next-state values so they can be registered
        // without adding a cycle of lag to the line.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = frm_par_bit_d;
`endif
            default:  tx_d = 1'b1;
        endcase
        busy_d  = (state_d != S_IDLE);
        ready_d = ~hold_full_d;
        done_d  = (state_d == S_STOP) && (baud_d == c_BAUD_LAST) &&
                  (!frm_stop2_d || (bit_d == 4'd1));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            baud_q       <= '0;
            bit_q        <= 4'd0;
            shift_q      <= '0;
            frm_stop2_q  <= 1'b0;
            hold_full_q  <= 1'b0;
            hold_data_q  <= '0;
            hold_stop2_q <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ready_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            hold_par_en_q  <= 1'b0;
            hold_par_bit_q <= 1'b0;
            frm_par_en_q   <= 1'b0;
            frm_par_bit_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            frm_stop2_q  <= frm_stop2_d;
            hold_full_q  <= hold_full_d;
            hold_data_q  <= hold_data_d;
            hold_stop2_q <= hold_stop2_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ready_q      <= ready_d;
`ifdef UART_TX_PARITY_EN
            hold_par_en_q  <= hold_par_en_d;
            hold_par_bit_q <= hold_par_bit_d;
            frm_par_en_q   <= frm_par_en_d;
            frm_par_bit_q  <= frm_par_bit_d;
`endif
        end
    end

    assign TX_OUT     = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign ready      = ready_q;

endmodule
`default_nettype wire
